// File: rtl/psum_accumulator.sv
// psum_accumulator: accumulates kij_len iterations of output-FIFO psum vectors into a buffer, then streams it out; define PSUM_SAT_EN for saturating lane adds.
module psum_accumulator #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int num_inp = 64,
    parameter int kij_len = 9
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   ofifo_valid,
    input  logic [col*psum_bw-1:0] ofifo_out,
    output logic                   ofifo_rd,
    input  logic                   relu,
    input  logic                   psum_rd,
    output logic [col*psum_bw-1:0] psum_mem_dout,
    output logic                   iter_done,
    output logic                   compute_done
);
    localparam int aw = $clog2(num_inp);
    localparam int iw = $clog2(kij_len);
    localparam int vw = col * psum_bw;

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t            state, state_nxt;
    logic [iw-1:0]     iter_cnt;
    logic [aw-1:0]     wr_addr, rd_addr;
    logic [vw-1:0]     mem [num_inp];
    logic [vw-1:0]     cur_wr, cur_rd, acc_row, rd_row, wr_data;
    logic              last_pop;

    function automatic logic [psum_bw-1:0] lane_add(input logic [psum_bw-1:0] a, input logic [psum_bw-1:0] b);
`ifdef PSUM_SAT_EN
        logic [psum_bw:0] s;
        s = {a[psum_bw-1], a} + {b[psum_bw-1], b};
        return (s[psum_bw] != s[psum_bw-1]) ? {s[psum_bw], {(psum_bw-1){~s[psum_bw]}}} : s[psum_bw-1:0];
`else
        return a + b;
`endif
    endfunction

    always_comb begin
        state_nxt = state;
        ofifo_rd  = 1'b0;
        last_pop  = 1'b0;
        case (state)
            IDLE: state_nxt = start ? ACC : IDLE;
            ACC: begin
                ofifo_rd = ofifo_valid;
                last_pop = ofifo_valid && wr_addr == aw'(num_inp - 1);
                if (last_pop && iter_cnt == iw'(kij_len - 1))
                    state_nxt = DONE;
            end
            DONE: state_nxt = start ? ACC : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    assign compute_done = state == DONE;
    assign cur_wr = mem[wr_addr];
    assign cur_rd = mem[rd_addr];

    always_comb begin
        acc_row = '0;
        rd_row  = '0;
        for (int k = 0; k < col; k++) begin
            acc_row[k*psum_bw +: psum_bw] = lane_add(cur_wr[k*psum_bw +: psum_bw], ofifo_out[k*psum_bw +: psum_bw]);
            rd_row[k*psum_bw +: psum_bw]  = (relu && cur_rd[(k+1)*psum_bw-1]) ? '0 : cur_rd[k*psum_bw +: psum_bw];
        end
    end

    // First iteration overwrites so stale rows from earlier runs never leak in
    assign wr_data = (iter_cnt == '0) ? ofifo_out : acc_row;

    always_ff @(posedge clk) begin
        if (ofifo_rd && !reset)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            iter_cnt      <= '0;
            wr_addr       <= '0;
            rd_addr       <= '0;
            iter_done     <= 1'b0;
            psum_mem_dout <= '0;
        end else begin
            state     <= state_nxt;
            iter_done <= last_pop;
            if (start && state != ACC) begin
                iter_cnt      <= '0;
                wr_addr       <= '0;
                rd_addr       <= '0;
                psum_mem_dout <= '0;
            end else if (ofifo_rd) begin
                wr_addr <= last_pop ? '0 : wr_addr + aw'(1);
                if (last_pop && iter_cnt != iw'(kij_len - 1))
                    iter_cnt <= iter_cnt + iw'(1);
            end else if (compute_done && psum_rd) begin
                psum_mem_dout <= rd_row;
                rd_addr       <= (rd_addr == aw'(num_inp - 1)) ? '0 : rd_addr + aw'(1);
            end
        end
    end
endmodule
